// File: rtl/sirv_gnrl_rrarb_buf.sv
// Round-robin arbiter sharing one load-enable holding register among N valid/ready writers.
// Latency: accept at edge t -> item on o_dat/o_src in cycle t+1; no combinational path i_dat -> o_dat.
// Backpressure: i_rdy depends combinationally on o_rdy; a held item with o_rdy=0 blocks every writer.
//
// Ports:
//   clk, rst_n          clock (posedge) and asynchronous active-low reset
//   i_vld/i_rdy/i_dat   N requesters; requester k owns i_dat[k*DW +: DW]; at most one i_rdy bit high
//   o_vld/o_rdy         downstream handshake for the holding register
//   o_dat/o_src         held data and the index of the requester that supplied it
//   busy                mirrors o_vld
module sirv_gnrl_rrarb_buf #(
    parameter  int N    = 4,
    parameter  int DW   = 32,
    localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        i_vld,
    output logic [N-1:0]        i_rdy,
    input  logic [N*DW-1:0]     i_dat,
    output logic                o_vld,
    input  logic                o_rdy,
    output logic [DW-1:0]       o_dat,
    output logic [IDXW-1:0]     o_src,
    output logic                busy
);

    logic                vld_q, vld_d;
    logic [IDXW-1:0]     ptr_q, ptr_d;
    logic [DW-1:0]       dat_q, dat_d;
    logic [IDXW-1:0]     src_q, src_d;

    logic                can_load;
    logic                accept;
    logic [N-1:0]        gnt;
    logic [IDXW-1:0]     gnt_idx;
    logic [DW-1:0]       gnt_dat;
    logic                found;

    // The slot is free when empty or when its current item leaves this cycle,
    // which lets the buffer drain and refill on the same edge.
    assign can_load = ~vld_q | o_rdy;

    // Rotating priority search: first pass covers ptr_q..N-1, second pass
    // wraps around to 0..ptr_q-1. Loop indices stay constant after unrolling.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && (k >= int'(ptr_q)) && i_vld[k]) begin
                gnt[k]  = 1'b1;
                gnt_idx = IDXW'(k);
                found   = 1'b1;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!found && (k < int'(ptr_q)) && i_vld[k]) begin
                gnt[k]  = 1'b1;
                gnt_idx = IDXW'(k);
                found   = 1'b1;
            end
        end
    end

    // One-hot grant selects the winning data word.
    always_comb begin
        gnt_dat = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt[k]) begin
                gnt_dat = i_dat[k*DW +: DW];
            end
        end
    end

    assign i_rdy  = gnt & {N{can_load}};
    assign accept = can_load & found;

    always_comb begin
        vld_d = vld_q;
        ptr_d = ptr_q;
        dat_d = dat_q;
        src_d = src_q;
        if (accept) begin
            vld_d = 1'b1;
            dat_d = gnt_dat;
            src_d = gnt_idx;
            // Priority moves to the requester just after the winner.
            ptr_d = (gnt_idx == IDXW'(N - 1)) ? '0 : IDXW'(gnt_idx + 1'b1);
        end else if (o_rdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            ptr_q <= '0;
            dat_q <= '0;
            src_q <= '0;
        end else begin
            vld_q <= vld_d;
            ptr_q <= ptr_d;
            dat_q <= dat_d;
            src_q <= src_d;
        end
    end

    assign o_vld = vld_q;
    assign busy  = vld_q;
    assign o_dat = dat_q;
    assign o_src = src_q;

endmodule

// File: tb/tb_sirv_gnrl_rrarb_buf.sv
module tb_sirv_gnrl_rrarb_buf;

    localparam int N  = 4;
    localparam int DW = 32;

    logic              clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [N-1:0]      i_vld, i_rdy;
    logic [N*DW-1:0]   i_dat;
    logic              o_vld, o_rdy, busy;
    logic [DW-1:0]     o_dat;
    logic [1:0]        o_src;

    logic [0:0]        s_i_vld, s_i_rdy;
    logic [7:0]        s_i_dat, s_o_dat;
    logic              s_o_vld, s_o_rdy, s_busy;
    logic [0:0]        s_o_src;

    sirv_gnrl_rrarb_buf #(.N(N), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_vld(i_vld), .i_rdy(i_rdy), .i_dat(i_dat),
        .o_vld(o_vld), .o_rdy(o_rdy), .o_dat(o_dat), .o_src(o_src),
        .busy(busy)
    );

    sirv_gnrl_rrarb_buf #(.N(1), .DW(8)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_vld(s_i_vld), .i_rdy(s_i_rdy), .i_dat(s_i_dat),
        .o_vld(s_o_vld), .o_rdy(s_o_rdy), .o_dat(s_o_dat), .o_src(s_o_src),
        .busy(s_busy)
    );

    typedef struct {
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] rdy;
    } vec_t;

    typedef struct {
        logic [DW-1:0] dat;
        logic [1:0]    src;
    } item_t;

    int    total = 0;
    int    bad   = 0;
    item_t sb[$];
    vec_t  tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle on the N=4 instance; expected i_rdy comes from the table,
    // expected output items come from the scoreboard.
    task automatic step(input logic [3:0] vld, input logic ordy, input logic [3:0] exp_rdy, input string nm);
        item_t it;
        @(negedge clk);
        i_vld = vld;
        o_rdy = ordy;
        for (int k = 0; k < N; k++) i_dat[k*DW +: DW] = $urandom;
        #1;
        chk({nm, " i_rdy"}, 64'(i_rdy), 64'(exp_rdy));
        chk({nm, " o_vld"}, 64'(o_vld), 64'(sb.size() != 0));
        chk({nm, " busy"},  64'(busy),  64'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk({nm, " o_dat"}, 64'(o_dat), 64'(sb[0].dat));
            chk({nm, " o_src"}, 64'(o_src), 64'(sb[0].src));
        end
        if (ordy && sb.size() != 0) void'(sb.pop_front());
        for (int k = 0; k < N; k++) begin
            if (exp_rdy[k]) begin
                it.dat = i_dat[k*DW +: DW];
                it.src = 2'(k);
                sb.push_back(it);
            end
        end
    endtask

    initial begin
        // Full rotation with all requesters active
        tbl.push_back('{4'b1111, 1'b1, 4'b0001});
        tbl.push_back('{4'b1111, 1'b1, 4'b0010});
        tbl.push_back('{4'b1111, 1'b1, 4'b0100});
        tbl.push_back('{4'b1111, 1'b1, 4'b1000});
        tbl.push_back('{4'b1111, 1'b1, 4'b0001});
        // Hold an item from requester 1 under backpressure, then drain+refill
        tbl.push_back('{4'b0010, 1'b1, 4'b0010});
        for (int i = 0; i < 5; i++) tbl.push_back('{4'b1111, 1'b0, 4'b0000});
        tbl.push_back('{4'b1000, 1'b1, 4'b1000});
        tbl.push_back('{4'b0000, 1'b0, 4'b0000});
        // Rotation past requester 2 favours 3 over 1
        tbl.push_back('{4'b0100, 1'b1, 4'b0100});
        tbl.push_back('{4'b1010, 1'b1, 4'b1000});
        tbl.push_back('{4'b1010, 1'b1, 4'b0010});
        tbl.push_back('{4'b0010, 1'b1, 4'b0010});
        tbl.push_back('{4'b0000, 1'b1, 4'b0000});
        tbl.push_back('{4'b0000, 1'b0, 4'b0000});
        // Pointer unchanged through idle cycles: search from 2 wraps to 0
        tbl.push_back('{4'b0011, 1'b1, 4'b0001});
        tbl.push_back('{4'b0000, 1'b1, 4'b0000});
        // Leave pointer at 3 with an item held, ahead of the reset pulse
        tbl.push_back('{4'b0100, 1'b1, 4'b0100});
        tbl.push_back('{4'b0000, 1'b0, 4'b0000});

        rst_n   = 1'b0;
        i_vld   = 4'b1111;
        o_rdy   = 1'b0;
        i_dat   = '0;
        s_i_vld = 1'b0;
        s_i_dat = 8'h00;
        s_o_rdy = 1'b0;

        #1;
        chk("rst i_rdy", 64'(i_rdy), 64'h1);
        chk("rst o_vld", 64'(o_vld), 64'h0);
        chk("rst o_dat", 64'(o_dat), 64'h0);
        chk("rst o_src", 64'(o_src), 64'h0);
        chk("rst busy",  64'(busy),  64'h0);
        @(negedge clk);
        chk("rst after edge o_vld", 64'(o_vld), 64'h0);
        chk("rst after edge i_rdy", 64'(i_rdy), 64'h1);
        chk("rst n1 o_vld", 64'(s_o_vld), 64'h0);
        rst_n = 1'b1;
        i_vld = 4'b0000;

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].vld, tbl[i].ordy, tbl[i].rdy, $sformatf("vec%0d", i));

        // Asynchronous reset pulse between edges drops the held item at once
        @(negedge clk);
        #1;
        chk("pre-pulse o_vld", 64'(o_vld), 64'(sb.size() != 0));
        rst_n = 1'b0;
        #1;
        chk("pulse o_vld", 64'(o_vld), 64'h0);
        chk("pulse busy",  64'(busy),  64'h0);
        chk("pulse o_dat", 64'(o_dat), 64'h0);
        chk("pulse o_src", 64'(o_src), 64'h0);
        rst_n = 1'b1;
        sb.delete();
        step(4'b1100, 1'b1, 4'b0100, "post_rst");
        step(4'b0000, 1'b1, 4'b0000, "post_rst_drain");
        step(4'b0000, 1'b0, 4'b0000, "post_rst_idle");

        // N=1 instance: back-to-back pipe register
        @(negedge clk);
        s_i_vld = 1'b1;
        s_i_dat = 8'hA5;
        s_o_rdy = 1'b1;
        #1;
        chk("n1 c0 i_rdy", 64'(s_i_rdy), 64'h1);
        chk("n1 c0 o_vld", 64'(s_o_vld), 64'h0);
        @(negedge clk);
        s_i_dat = 8'h3C;
        #1;
        chk("n1 c1 i_rdy", 64'(s_i_rdy), 64'h1);
        chk("n1 c1 o_vld", 64'(s_o_vld), 64'h1);
        chk("n1 c1 o_dat", 64'(s_o_dat), 64'hA5);
        chk("n1 c1 o_src", 64'(s_o_src), 64'h0);
        @(negedge clk);
        s_i_vld = 1'b0;
        #1;
        chk("n1 c2 o_vld", 64'(s_o_vld), 64'h1);
        chk("n1 c2 o_dat", 64'(s_o_dat), 64'h3C);
        chk("n1 c2 i_rdy", 64'(s_i_rdy), 64'h0);
        @(negedge clk);
        #1;
        chk("n1 c3 o_vld", 64'(s_o_vld), 64'h0);
        chk("n1 c3 busy",  64'(s_busy),  64'h0);
        chk("n1 c3 o_dat", 64'(s_o_dat), 64'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
